// File: rtl/piso_tx.sv
// piso_tx: WIDTH-bit parallel-in, serial-out frame transmitter (start, data LSB first, [parity], stop).
// Optional feature macro: PISO_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic [WIDTH-1:0] w,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t           r_state, w_state;
    logic [DW-1:0]    r_div, w_div;
    logic [BW-1:0]    r_bit, w_bit;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic             r_sout, w_sout;
    logic             r_ready, w_ready;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             w_tick;
`ifdef PISO_TX_PARITY_EN
    logic             r_par, w_par;
`endif

    assign w_tick = (r_div == DW'(DIV - 1));

    // Next-state logic; outputs are computed for the next state so they leave registers.
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_sout  = 1'b1;
        w_ready = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        w_par   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (load && r_ready) begin
                    w_state = S_START;
                    w_shift = w;
                    w_div   = '0;
                    w_bit   = '0;
                    w_sout  = 1'b0;
`ifdef PISO_TX_PARITY_EN
                    w_par   = even_parity(w);
`endif
                end else begin
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state = S_DATA;
                    w_div   = '0;
                    w_sout  = r_shift[0];
                end else begin
                    w_div   = r_div + DW'(1);
                    w_sout  = 1'b0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_div = '0;
                    if (r_bit == BW'(WIDTH - 1)) begin
                        w_bit   = '0;
`ifdef PISO_TX_PARITY_EN
                        w_state = S_PAR;
                        w_sout  = r_par;
`else
                        w_state = S_STOP;
                        w_sout  = 1'b1;
`endif
                    end else begin
                        w_bit   = r_bit + BW'(1);
                        w_shift = {1'b0, r_shift[WIDTH-1:1]};
                        w_sout  = r_shift[1];
                    end
                end else begin
                    w_div  = r_div + DW'(1);
                    w_sout = r_shift[0];
                end
            end
`ifdef PISO_TX_PARITY_EN
            S_PAR: begin
                if (w_tick) begin
                    w_state = S_STOP;
                    w_div   = '0;
                    w_sout  = 1'b1;
                end else begin
                    w_div   = r_div + DW'(1);
                    w_sout  = r_par;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_state = S_IDLE;
                    w_div   = '0;
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_div   = r_div + DW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_div   = '0;
                w_bit   = '0;
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns the line high immediately.
    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sout  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_sout  <= w_sout;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef PISO_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign ready = r_ready;
    assign sout  = r_sout;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
